// File: rtl/trivium_feeder.sv
// Byte-to-bit feeder for a Trivium cipher core: collects key/IV, serialises
// it behind an init pulse, waits out the core warm-up, then streams message
// bytes LSB first with a one-byte holding register and zero-fill on underrun.
module trivium_feeder #(
    parameter int BUSY_TMO = 15
) (
    input  logic       clk_i,
    input  logic       n_rst_i,
    input  logic       start_i,
    input  logic [7:0] byte_i,
    input  logic       byte_valid_i,
    input  logic       byte_last_i,
    output logic       byte_ready_o,
    input  logic       busy_init_i,
    output logic       dat_o,
    output logic       init_o,
    output logic       end_o,
    output logic       busy_o,
    output logic       underrun_o,
    output logic       err_o
);

    typedef enum logic [2:0] {
        IDLE, COLLECT, SEND_KEYIV, WAIT_BUSY, WARM, WAIT_DATA, START_PROC, STREAM
    } state_t;

    localparam logic [7:0] LAST_KEY_BYTE = 8'd19;
    localparam logic [7:0] LAST_KEY_BIT  = 8'd160;
    localparam logic [7:0] TMO_LAST      = 8'(BUSY_TMO - 1);

    state_t       state_q, state_d;
    logic [159:0] keyiv_q;      // byte 0 ends up in [7:0]; shifted right while sending
    logic [7:0]   cnt_q;        // byte count, key bit count, then timeout count
    logic [7:0]   sreg_q;       // byte currently on dat_o, LSB first
    logic         last_q;       // sreg_q holds the final message byte
    logic [7:0]   hold_q;
    logic         hold_valid_q;
    logic         hold_last_q;
    logic [2:0]   bit_q;        // bit position within sreg_q
    logic         underrun_q;
    logic         err_q;

    logic xfer;
    logic bit7;

    assign xfer = byte_valid_i & byte_ready_o;
    assign bit7 = (bit_q == 3'd7);

    // State register.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q <= IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default first so no path through the case leaves state_d
        // unassigned, which would infer a latch.
        state_d = state_q;
        case (state_q)
            IDLE:       if (start_i) state_d = COLLECT;
            COLLECT:    if (xfer && cnt_q == LAST_KEY_BYTE) state_d = SEND_KEYIV;
            SEND_KEYIV: if (cnt_q == LAST_KEY_BIT) state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (busy_init_i)            state_d = WARM;
                else if (cnt_q == TMO_LAST) state_d = IDLE;
            end
            WARM:       if (!busy_init_i) state_d = WAIT_DATA;
            WAIT_DATA:  if (xfer) state_d = START_PROC;
            START_PROC: state_d = STREAM;
            STREAM:     if (bit7 && last_q) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Outputs decoded from registered state only, so reset clears them at once.
    always_comb begin
        byte_ready_o = 1'b0;
        dat_o        = 1'b0;
        init_o       = 1'b0;
        end_o        = 1'b0;
        case (state_q)
            COLLECT:    byte_ready_o = 1'b1;
            SEND_KEYIV: begin
                init_o = (cnt_q == 8'd0);
                dat_o  = (cnt_q != 8'd0) & keyiv_q[0];
            end
            WAIT_DATA:  byte_ready_o = 1'b1;
            START_PROC: begin
                init_o       = 1'b1;
                byte_ready_o = !hold_valid_q;
            end
            STREAM: begin
                dat_o        = sreg_q[0];
                end_o        = bit7 & last_q;
                byte_ready_o = !hold_valid_q;
            end
            default: ;
        endcase
    end

    assign busy_o     = (state_q != IDLE);
    assign underrun_o = underrun_q;
    assign err_o      = err_q;

    // Datapath: key/IV collection and shift-out, counters, byte streaming.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            // NOTE: the key/IV register is reset too, so a reset mid-session
            // leaves no key material behind.
            keyiv_q      <= '0;
            cnt_q        <= '0;
            sreg_q       <= '0;
            last_q       <= 1'b0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            hold_last_q  <= 1'b0;
            bit_q        <= '0;
            underrun_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        underrun_q   <= 1'b0;
                        err_q        <= 1'b0;
                        cnt_q        <= '0;
                        hold_valid_q <= 1'b0;
                        last_q       <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (xfer) begin
                        keyiv_q <= {byte_i, keyiv_q[159:8]};
                        cnt_q   <= (cnt_q == LAST_KEY_BYTE) ? 8'd0 : cnt_q + 8'd1;
                    end
                end
                SEND_KEYIV: begin
                    if (cnt_q != 8'd0) keyiv_q <= {1'b0, keyiv_q[159:1]};
                    cnt_q <= (cnt_q == LAST_KEY_BIT) ? 8'd0 : cnt_q + 8'd1;
                end
                WAIT_BUSY: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (!busy_init_i && cnt_q == TMO_LAST) err_q <= 1'b1;
                end
                WAIT_DATA: begin
                    if (xfer) begin
                        sreg_q <= byte_i;
                        last_q <= byte_last_i;
                        bit_q  <= '0;
                    end
                end
                START_PROC: begin
                    if (xfer) begin
                        hold_q       <= byte_i;
                        hold_last_q  <= byte_last_i;
                        hold_valid_q <= 1'b1;
                    end
                end
                STREAM: begin
                    bit_q  <= bit_q + 3'd1;
                    sreg_q <= {1'b0, sreg_q[7:1]};
                    if (bit7) begin
                        if (last_q) begin
                            hold_valid_q <= 1'b0;
                            last_q       <= 1'b0;
                        end else if (hold_valid_q) begin
                            sreg_q       <= hold_q;
                            last_q       <= hold_last_q;
                            hold_valid_q <= 1'b0;
                        end else if (xfer) begin
                            // Byte arriving exactly at the handoff bypasses the holding register.
                            sreg_q <= byte_i;
                            last_q <= byte_last_i;
                        end else begin
                            // Core cannot stall: fill with a zero byte and flag it.
                            sreg_q     <= 8'h00;
                            last_q     <= 1'b0;
                            underrun_q <= 1'b1;
                        end
                    end else if (xfer) begin
                        hold_q       <= byte_i;
                        hold_last_q  <= byte_last_i;
                        hold_valid_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
